// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier
//   Sequential radix-2 Booth multiplier. It produces a WIDTH x WIDTH -> 2*WIDTH
//   product and performs one add/subtract plus shift per clock. Signed or
//   unsigned operands are chosen per operation.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request; accepted in IDLE or DONE, ignored while busy
//   signed_mode  1 = two's-complement operands, 0 = unsigned (captured with x/y)
//   x            multiplicand
//   y            multiplier
//   busy         high for the WIDTH+1 cycles of a multiply
//   done         one-cycle pulse when z carries a new result
//   z            product, held until the next result or reset
module seq_booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);

    // The step counter runs from 0 to WIDTH, which is WIDTH+1 steps in total.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH+1:0] a;
    logic [WIDTH+1:0] m;
    logic [WIDTH:0]   q;
    logic             q_1;
    logic [CW-1:0]    count;

    logic             capture;
    logic             last_step;
    logic [WIDTH:0]   x_ext;
    logic [WIDTH:0]   y_ext;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] a_shift;
    logic [WIDTH:0]   q_shift;

    // Extending each operand by one bit lets unsigned operands run through
    // the same signed Booth datapath. Zero-extension keeps them non-negative.
    assign x_ext     = {signed_mode & x[WIDTH-1], x};
    assign y_ext     = {signed_mode & y[WIDTH-1], y};
    assign capture   = start && (state != RUN);
    assign last_step = (count == CW'(WIDTH));

    // Booth recode of {Q[0], q_1}, then an arithmetic right shift of {A,Q,q_1}.
    always_comb begin
        sum = a;
        unique case ({q[0], q_1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_shift = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_shift = {sum[0], q[WIDTH:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            z     <= '0;
        end else if (capture) begin
            a     <= '0;
            m     <= {x_ext[WIDTH], x_ext};
            q     <= y_ext;
            q_1   <= 1'b0;
            count <= '0;
        end else if (state == RUN) begin
            a     <= a_shift;
            q     <= q_shift;
            q_1   <= q[0];
            count <= count + 1'b1;
            // The exact product always fits in 2*WIDTH bits, so the upper
            // bits of {A,Q} are only sign copies and are dropped.
            if (last_step) z <= {a_shift[WIDTH-2:0], q_shift};
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier
//   Scoreboard bench. It runs independent DUT instances at several widths.
//   Each driver pushes the expected product and its capture cycle when an
//   operation is accepted. Each monitor pops and compares on every done pulse.
module tb_seq_booth_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks      = 0;
    int passes      = 0;
    int blocks_done = 0;

    task automatic check(input bit ok, input string name,
                         input longint act, input longint req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    for (genvar g = 0; g < 5; g++) begin : u
        localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 2 : (g == 3) ? 5 : 16;

        typedef struct {
            longint p;
            int     cyc;
        } exp_t;

        logic             rst   = 1'b1;
        logic             start = 1'b0;
        logic             sm    = 1'b0;
        logic [W-1:0]     x     = '0;
        logic [W-1:0]     y     = '0;
        logic             busy;
        logic             done;
        logic [2*W-1:0]   z;
        logic [2*W-1:0]   last_z = '0;

        exp_t sb[$];
        int   cycle    = 0;
        int   accepted = 0;
        int   dones    = 0;
        int   aborted  = 0;
        int   busy_run = 0;

        seq_booth_multiplier #(.WIDTH(W)) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .signed_mode (sm),
            .x           (x),
            .y           (y),
            .busy        (busy),
            .done        (done),
            .z           (z)
        );

        always @(posedge clk) cycle++;

        // Reference: an integer product of the interpreted operands, cut to 2*W bits.
        function automatic longint ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input bit s);
            longint av;
            longint bv;
            av = s ? longint'($signed(a)) : longint'(a);
            bv = s ? longint'($signed(b)) : longint'(b);
            return (av * bv) & ((64'sd1 <<< (2 * W)) - 64'sd1);
        endfunction

        // While the DUT is busy, the bus shows garbage with start high. Once it
        // is free, the real operands are presented for capture.
        task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit s, input bit hold);
            bit got;
            exp_t e;
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (busy) begin
                    x     = W'($urandom);
                    y     = W'($urandom);
                    sm    = 1'($urandom);
                    start = 1'b1;
                end else begin
                    x     = a;
                    y     = b;
                    sm    = s;
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    e.p   = ref_prod(a, b, s);
                    e.cyc = cycle;
                    sb.push_back(e);
                    accepted++;
                    got = 1'b1;
                    if (!hold) start = 1'b0;
                end
            end
            check(got, "issue_wait", longint'(got), 1);
        endtask

        always @(negedge clk) begin
            if (rst) begin
                busy_run = 0;
                last_z   = '0;
            end else begin
                if (busy) begin
                    busy_run++;
                    check(z == last_z, "z_held_during_run", longint'(z), longint'(last_z));
                end
                if (done) begin
                    exp_t e;
                    dones++;
                    check(!busy, "done_busy_overlap", longint'(busy), 0);
                    check(busy_run == W + 1, "busy_length", busy_run, W + 1);
                    busy_run = 0;
                    check(sb.size() != 0, "done_has_expected", sb.size(), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check(longint'(z) == e.p, "product", longint'(z), e.p);
                        check(cycle - e.cyc == W + 1, "latency", cycle - e.cyc, W + 1);
                    end
                    last_z = z;
                end
            end
        end

        initial begin
            logic [W-1:0] pats[5];
            logic [W-1:0] msb;
            msb     = '0;
            msb[W-1] = 1'b1;
            pats[0] = '0;
            pats[1] = W'(1);
            pats[2] = '1;
            pats[3] = msb;
            pats[4] = ~msb;

            #1;
            check(busy == 1'b0, "reset_busy", longint'(busy), 0);
            check(done == 1'b0, "reset_done", longint'(done), 0);
            check(z == '0, "reset_z", longint'(z), 0);
            repeat (2) @(posedge clk);
            #2 rst = 1'b0;

            // Extreme operand pairs, back to back with start held high.
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        issue(pats[i], pats[j], s[0], 1'b1);
            start = 1'b0;

            // Random operands, with random holds and idle gaps.
            for (int k = 0; k < 40; k++) begin
                issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                if ($urandom_range(0, 2) == 0) begin
                    start = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            start = 1'b0;
            for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);

            // Asynchronous abort partway through a run.
            issue(pats[3], pats[4], 1'b1, 1'b0);
            repeat (2) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check(busy == 1'b0, "abort_busy", longint'(busy), 0);
            check(done == 1'b0, "abort_done", longint'(done), 0);
            check(z == '0, "abort_z", longint'(z), 0);
            aborted += sb.size();
            sb.delete();
            @(posedge clk);
            #2 rst = 1'b0;
            repeat (W + 3) @(negedge clk);

            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
            check(sb.size() == 0, "drain", sb.size(), 0);
            repeat (2) @(negedge clk);
            check(dones + aborted == accepted, "done_count", dones + aborted, accepted);
            blocks_done++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && blocks_done < 5; t++) @(posedge clk);
        check(blocks_done == 5, "all_blocks_finished", blocks_done, 5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
